bram_sdp_be: RTL and testbench

Parametrised simple dual-port, single-clock block RAM with per-byte write enables, selectable read latency, read-valid tracking and a hardware clear engine that zeroes the array after reset. It replaces the fixed 8-bit generic BRAM wrapper as the storage primitive behind the UART TX/RX buffers and any future packet or register-file storage. It targets inference as a single FPGA BRAM primitive.

---
 rtl/fpga_uart_pkg.sv | 35 +++
 rtl/bram_rd_pipe.sv | 40 ++++
 rtl/bram_sdp_be.sv | 181 ++++++++++++++++++
 tb/tb_bram_sdp_be.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_uart_pkg.sv
// ============================================================================
// Module   : fpga_uart_pkg
// Purpose  : Shared FSM encodings and parameter legality helpers for bram_sdp_be.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef FPGA_UART_PKG_SV
`define FPGA_UART_PKG_SV

// Elaboration-time guard; expands to a labelled generate-if in the caller's scope.
`define BRAM_SDP_PARAM_CHECK(W, B, L, D) \
  if ((((W) % (B)) != 0) || !fpga_uart_pkg::bram_lat_legal(L) || ((D) < 2)) begin : g_param_err \
    $error("bram_sdp_be: illegal parameter combination"); \
  end

package fpga_uart_pkg;

  typedef logic [0:0] bram_state_t;

  localparam bram_state_t BRAM_ST_CLEAR = 1'b0;
  localparam bram_state_t BRAM_ST_READY = 1'b1;

  localparam int BRAM_RD_LAT_MIN = 1;
  localparam int BRAM_RD_LAT_MAX = 2;

  function automatic bit bram_lat_legal(input int lat);
    return (lat >= BRAM_RD_LAT_MIN) && (lat <= BRAM_RD_LAT_MAX);
  endfunction

endpackage

`endif

`default_nettype wire

// File: rtl/bram_rd_pipe.sv
// ============================================================================
// Module   : bram_rd_pipe
// Purpose  : Optional output register stage (data + valid) for the BRAM read path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_rd_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // Data only advances with a valid beat so the output holds between reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/bram_sdp_be.sv
// ============================================================================
// Module   : bram_sdp_be
// Purpose  : Simple dual-port single-clock BRAM with byte enables, 1/2-cycle
//            read latency and a post-reset clear engine.
//            Macro BRAM_SDP_BYPASS_EN selects write-first collision behaviour.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_sdp_be
  import fpga_uart_pkg::*;
#(
  parameter  int RAM_WIDTH  = 32,
  parameter  int RAM_DEPTH  = 256,
  parameter  int BYTE_WIDTH = 8,
  parameter  int RD_LATENCY = 1,
  localparam int NumBytes   = RAM_WIDTH / BYTE_WIDTH,
  localparam int AddrWidth  = $clog2(RAM_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [NumBytes-1:0]  wr_be_i,
  input  logic [AddrWidth-1:0] wr_addr_i,
  input  logic [RAM_WIDTH-1:0] wr_data_i,
  input  logic                 rd_en_i,
  input  logic [AddrWidth-1:0] rd_addr_i,
  output logic [RAM_WIDTH-1:0] rd_data_o,
  output logic                 rd_valid_o,
  output logic                 busy_o
);

  `BRAM_SDP_PARAM_CHECK(RAM_WIDTH, BYTE_WIDTH, RD_LATENCY, RAM_DEPTH)

  localparam logic [AddrWidth:0]   C_DEPTH_EXT = (AddrWidth + 1)'(RAM_DEPTH);
  localparam logic [AddrWidth-1:0] C_LAST_ADDR = AddrWidth'(RAM_DEPTH - 1);

  logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];

  bram_state_t          state_q, state_d;
  logic [AddrWidth-1:0] clr_cnt_q, clr_cnt_d;
  logic                 busy_q, busy_d;

  logic                 w_ready;
  logic                 w_wr_in_range;
  logic                 w_rd_in_range;
  logic                 w_wr_fire;
  logic                 w_rd_fire;
  logic [NumBytes-1:0]  w_we;
  logic [AddrWidth-1:0] w_waddr;
  logic [RAM_WIDTH-1:0] w_wdata;

  logic                 rd_v1_q;
  logic [RAM_WIDTH-1:0] rd_raw_q;
  logic [RAM_WIDTH-1:0] w_rd_s1_data;

  assign w_ready       = (state_q == BRAM_ST_READY);
  assign w_wr_in_range = ({1'b0, wr_addr_i} < C_DEPTH_EXT);
  assign w_rd_in_range = ({1'b0, rd_addr_i} < C_DEPTH_EXT);
  assign w_wr_fire     = w_ready && !rst_i && wr_en_i && w_wr_in_range;
  assign w_rd_fire     = w_ready && !rst_i && rd_en_i;

  // ---------------------------------------------------------------- clear FSM
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy_d    = busy_q;
    if (state_q == BRAM_ST_CLEAR) begin
      if (clr_cnt_q == C_LAST_ADDR) begin
        state_d   = BRAM_ST_READY;
        clr_cnt_d = '0;
        busy_d    = 1'b0;
      end else begin
        clr_cnt_d = clr_cnt_q + AddrWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= BRAM_ST_CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign busy_o = busy_q;

  // ------------------------------------------------- shared array write port
  // The clear engine and user writes share one port so the array maps to a
  // single BRAM primitive; they are mutually exclusive by FSM state.
  always_comb begin
    w_we    = '0;
    w_waddr = wr_addr_i;
    w_wdata = wr_data_i;
    if (!rst_i) begin
      if (state_q == BRAM_ST_CLEAR) begin
        w_we    = '1;
        w_waddr = clr_cnt_q;
        w_wdata = '0;
      end else if (w_wr_fire) begin
        w_we = wr_be_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NumBytes; k++) begin
      if (w_we[k]) begin
        mem_q[w_waddr][k*BYTE_WIDTH +: BYTE_WIDTH] <= w_wdata[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // ------------------------------------------------------ read port, stage 1
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_v1_q  <= 1'b0;
      rd_raw_q <= '0;
    end else begin
      rd_v1_q <= w_rd_fire;
      if (w_rd_fire) begin
        rd_raw_q <= w_rd_in_range ? mem_q[rd_addr_i] : '0;
      end
    end
  end

`ifdef BRAM_SDP_BYPASS_EN
  logic [NumBytes-1:0]  fwd_be_q;
  logic [RAM_WIDTH-1:0] fwd_data_q;

  // Capture colliding write bytes alongside the read; the array itself
  // still returns pre-write data, and the merge happens after the register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fwd_be_q   <= '0;
      fwd_data_q <= '0;
    end else if (w_rd_fire) begin
      fwd_be_q   <= (w_wr_fire && (wr_addr_i == rd_addr_i)) ? wr_be_i : '0;
      fwd_data_q <= wr_data_i;
    end
  end

  always_comb begin
    w_rd_s1_data = rd_raw_q;
    for (int k = 0; k < NumBytes; k++) begin
      if (fwd_be_q[k]) begin
        w_rd_s1_data[k*BYTE_WIDTH +: BYTE_WIDTH] = fwd_data_q[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end
`else
  assign w_rd_s1_data = rd_raw_q;
`endif

  // ------------------------------------------------------------ output stage
  generate
    if (RD_LATENCY == 2) begin : g_lat2
      bram_rd_pipe #(
        .WIDTH (RAM_WIDTH)
      ) u_rd_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (rd_v1_q),
        .data_i  (w_rd_s1_data),
        .valid_o (rd_valid_o),
        .data_o  (rd_data_o)
      );
    end else begin : g_lat1
      assign rd_valid_o = rd_v1_q;
      assign rd_data_o  = w_rd_s1_data;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_bram_sdp_be.sv
// ============================================================================
// Module   : tb_bram_sdp_be
// Purpose  : Self-checking bench for bram_sdp_be (latency 1 and 2 instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_sdp_be;

  localparam int D = 256;

  logic        clk = 1'b0;
  logic        rst, wr_en, rd_en;
  logic [3:0]  wr_be;
  logic [7:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data1, rd_data2;
  logic        rd_valid1, rd_valid2, busy1, busy2;

  always #5 clk = ~clk;

  bram_sdp_be #(.RAM_WIDTH(32), .RAM_DEPTH(D), .BYTE_WIDTH(8), .RD_LATENCY(1)) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_be_i(wr_be), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data1), .rd_valid_o(rd_valid1), .busy_o(busy1));

  bram_sdp_be #(.RAM_WIDTH(32), .RAM_DEPTH(D), .BYTE_WIDTH(8), .RD_LATENCY(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_be_i(wr_be), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data2), .rd_valid_o(rd_valid2), .busy_o(busy2));

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ------------------------------------------------------------------ model
  logic [31:0] mem [D];
  bit          armed = 1'b0;
  bit          mbusy;
  int          mclr_left;
  bit          e1_v, e2_v, p_v;
  logic [31:0] e1_d, e2_d, p_d;

  task automatic model_step();
    bit          rv;
    logic [31:0] rdv;
    rv  = 1'b0;
    rdv = '0;
    if (rst) begin
      armed = 1'b1; mbusy = 1'b1; mclr_left = D;
      e1_v = 1'b0; e1_d = '0; e2_v = 1'b0; e2_d = '0; p_v = 1'b0; p_d = '0;
      return;
    end
    if (!armed) return;
    if (mbusy) begin
      mem[D - mclr_left] = '0;
      mclr_left--;
      if (mclr_left == 0) mbusy = 1'b0;
    end else begin
      if (rd_en) begin
        rv  = 1'b1;
        rdv = mem[rd_addr];
`ifdef BRAM_SDP_BYPASS_EN
        if (wr_en && wr_addr == rd_addr)
          for (int k = 0; k < 4; k++) if (wr_be[k]) rdv[k*8 +: 8] = wr_data[k*8 +: 8];
`endif
      end
      if (wr_en)
        for (int k = 0; k < 4; k++) if (wr_be[k]) mem[wr_addr][k*8 +: 8] = wr_data[k*8 +: 8];
    end
    e2_v = p_v;
    if (p_v) e2_d = p_d;
    p_v = rv;
    if (rv) p_d = rdv;
    e1_v = rv;
    if (rv) e1_d = rdv;
  endtask

  // ------------------------------------------------------- compare process
  int          cyc = 0;
  int          vcount1 = 0, vcount2 = 0, nz1 = 0;
  int          fv1 = -1, fv2 = -1, lv1 = -1;
  logic [31:0] q1[$];

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    model_step();
    if (armed) begin
      chk("busy1",  32'(busy1),     32'(mbusy));
      chk("valid1", 32'(rd_valid1), 32'(e1_v));
      chk("data1",  rd_data1,       e1_d);
      chk("busy2",  32'(busy2),     32'(mbusy));
      chk("valid2", 32'(rd_valid2), 32'(e2_v));
      chk("data2",  rd_data2,       e2_d);
      if (rd_valid1 === 1'b1) begin
        vcount1++;
        if (rd_data1 !== 32'h0) nz1++;
        q1.push_back(rd_data1);
        if (fv1 < 0) fv1 = cyc;
        lv1 = cyc;
      end
      if (rd_valid2 === 1'b1) begin
        vcount2++;
        if (fv2 < 0) fv2 = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------------- stimulus
  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be; rd_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    @(negedge clk);
    rd_en = 1'b1; rd_addr = a; wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rd_en = 1'b0; wr_en = 1'b0;
    end
  endtask

  // Called at a negedge with rst just released; counts busy cycles while
  // poking requests at addresses the clear engine has already zeroed.
  task automatic clear_loop(inout int cnt);
    for (int i = 0; i < 600; i++) begin
      wr_en   = (i >= 10 && i < 16);
      rd_en   = (i >= 10 && i < 16);
      wr_be   = 4'hF;
      wr_addr = 8'(i - 8);
      rd_addr = 8'(i - 8);
      wr_data = 32'hCAFE0000 + 32'(i);
      @(posedge clk);
      #2;
      if (busy1 !== 1'b1) break;
      cnt++;
      @(negedge clk);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  int busy_cnt, v0, v1s, v2s, issue;

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_be = '0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    for (int i = 0; i < D; i++) begin
      dut.mem_q[i]  = 32'hFFFFFFFF;
      dut2.mem_q[i] = 32'hFFFFFFFF;
      mem[i]        = 32'hFFFFFFFF;
    end

    // Reset and clear
    @(posedge clk);
    #2;
    chk("rst_valid", 32'(rd_valid1), 32'h0);
    chk("rst_data",  rd_data1,       32'h0);
    chk("rst_busy",  32'(busy1),     32'h1);
    busy_cnt = 1;
    @(negedge clk);
    rst = 1'b0;
    clear_loop(busy_cnt);
    chk("busy_cycles", 32'(busy_cnt), 32'd256);
    chk("clear_no_valid1", 32'(vcount1), 32'h0);
    chk("clear_no_valid2", 32'(vcount2), 32'h0);

    v0 = vcount1;
    for (int a = 0; a < D; a++) rd(8'(a));
    idle(3);
    chk("clear_readback_cnt", 32'(vcount1 - v0), 32'd256);
    chk("clear_readback_nz",  32'(nz1),          32'h0);

    // Byte enables
    wr(8'd5, 32'h11223344, 4'b1111);
    wr(8'd5, 32'hAABBCCDD, 4'b0101);
    rd(8'd5);
    idle(3);
    chk("be_merge1", rd_data1, 32'h11BB33DD);
    chk("be_merge2", rd_data2, 32'h11BB33DD);

    // Latency and throughput
    for (int i = 0; i < 8; i++) wr(8'(i), 32'(i), 4'hF);
    q1.delete(); fv1 = -1; fv2 = -1; lv1 = -1;
    rd(8'd0);
    issue = cyc + 1;
    for (int i = 1; i < 8; i++) rd(8'(i));
    idle(4);
    chk("lat1_first", 32'(fv1), 32'(issue));
    chk("lat2_first", 32'(fv2), 32'(issue + 1));
    chk("train_len",  32'(q1.size()), 32'd8);
    chk("train_span", 32'(lv1 - fv1 + 1), 32'd8);
    for (int i = 0; i < 8 && i < q1.size(); i++) chk("train_data", q1[i], 32'(i));

    // Same-cycle collision
    wr(8'd9, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 8'd9; wr_data = 32'h12345678; wr_be = 4'b1100;
    rd_en = 1'b1; rd_addr = 8'd9;
    idle(3);
`ifdef BRAM_SDP_BYPASS_EN
    chk("collide1", rd_data1, 32'h1234BEEF);
    chk("collide2", rd_data2, 32'h1234BEEF);
`else
    chk("collide1", rd_data1, 32'hDEADBEEF);
    chk("collide2", rd_data2, 32'hDEADBEEF);
`endif
    rd(8'd9);
    idle(3);
    chk("post_collide", rd_data1, 32'h1234BEEF);

    // Reset mid-read on the 2-cycle instance
    v1s = vcount1;
    v2s = vcount2;
    rd(8'd5);
    @(negedge clk);
    rst = 1'b1; rd_en = 1'b0;
    @(posedge clk);
    #2;
    chk("midrst_valid2", 32'(rd_valid2), 32'h0);
    chk("midrst_data2",  rd_data2,       32'h0);
    chk("midrst_busy2",  32'(busy2),     32'h1);
    busy_cnt = 1;
    @(negedge clk);
    rst = 1'b0;
    clear_loop(busy_cnt);
    chk("midrst_busy_cycles", 32'(busy_cnt), 32'd256);
    chk("midrst_no_valid2", 32'(vcount2 - v2s), 32'h0);
    chk("midrst_valid1_cnt", 32'(vcount1 - v1s), 32'h1);
    rd(8'd9);
    idle(3);
    chk("after_reclear", rd_data1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
